// File: rtl/alu_issue_wb.sv
// Issue/writeback controller: instruction FIFO -> S1 issue register -> S2 writeback register,
// with a one-bubble read-after-write interlock against the instruction currently in S1.
module alu_issue_wb #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_instr,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        out_valid,
    output logic        out_zero,
    output logic        out_carry
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = 32;

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;

    logic          s1_valid_q, s1_valid_d;
    logic [IW-1:0] s1_instr_q, s1_instr_d;

    logic          s2_valid_q, s2_valid_d;
    logic [4:0]    s2_rd_q, s2_rd_d;
    logic [31:0]   s2_data_q, s2_data_d;
    logic          s2_zero_q, s2_zero_d;
    logic          s2_carry_q, s2_carry_d;

    logic [IW-1:0] head_c;
    logic          hazard_c;
    logic          push_c;
    logic          pop_c;

    // Next-state: FIFO bookkeeping, issue with RAW interlock, writeback capture.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        s2_rd_d     = s2_rd_q;
        s2_data_d   = s2_data_q;
        s2_zero_d   = s2_zero_q;
        s2_carry_d  = s2_carry_q;

        head_c   = mem_q[rd_ptr_q];
        hazard_c = s1_valid_q &&
                   ((head_c[25:21] == s1_instr_q[15:11]) ||
                    (head_c[20:16] == s1_instr_q[15:11]));
        push_c   = in_valid && in_ready_q;
        pop_c    = (count_q != CW'(0)) && !hazard_c;

        if (push_c) begin
            mem_d[wr_ptr_q] = in_instr;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        in_ready_d = (count_d != CW'(DEPTH));

        // A bubble loads zero so alu_instr comes straight from the register.
        s1_valid_d = pop_c;
        s1_instr_d = pop_c ? head_c : '0;

        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            s2_rd_d    = s1_instr_q[15:11];
            s2_data_d  = alu_result;
            s2_zero_d  = alu_zero;
            s2_carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= '0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b0;
            s2_carry_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            s1_valid_q <= s1_valid_d;
            s1_instr_q <= s1_instr_d;
            s2_valid_q <= s2_valid_d;
            s2_rd_q    <= s2_rd_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_carry_q <= s2_carry_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_instr = s1_instr_q;
    assign wb_en     = s2_valid_q;
    assign out_valid = s2_valid_q;
    assign wb_addr   = s2_rd_q;
    assign wb_data   = s2_data_q;
    assign out_zero  = s2_zero_q;
    assign out_carry = s2_carry_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: the bench models the register file and an adder datapath.
module tb_alu_issue_wb;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_instr;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_zero;
    logic        out_carry;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [32];
    logic [32:0] sum;

    alu_issue_wb #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_instr  (alu_instr),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_zero   (out_zero),
        .out_carry  (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: r0=7 so a bubble's datapath output is distinguishable from held values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'd16;
            rf[0] <= 32'd7;
            rf[1] <= 32'd2;
            rf[2] <= 32'd3;
            rf[8] <= 32'hFFFF_FFFF;
            rf[9] <= 32'd1;
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        sum = {1'b0, rf[alu_instr[25:21]]} + {1'b0, rf[alu_instr[20:16]]};
    end
    assign alu_result = sum[31:0];
    assign alu_zero   = (sum[31:0] == 32'd0);
    assign alu_carry  = sum[32];

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int k;
    int n_wb;
    logic acc;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_instr", alu_instr, 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {30'd0, out_zero, out_carry}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single op: r3 = r1 + r2 = 5
        in_valid = 1'b1;
        in_instr = mk(1, 2, 3);
        tick();
        in_valid = 1'b0;
        check("single_not_yet", alu_instr, 32'd0);
        tick();
        check("single_issue", alu_instr, mk(1, 2, 3));
        check("single_no_wb_yet", 32'(wb_en), 32'd0);
        tick();
        check("single_wb_en", 32'(wb_en), 32'd1);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_wb_addr", 32'(wb_addr), 32'd3);
        check("single_wb_data", wb_data, 32'd5);
        check("single_flags", {30'd0, out_zero, out_carry}, 32'd0);
        tick();
        check("single_pulse_end", 32'(wb_en), 32'd0);
        check("single_data_hold", wb_data, 32'd5);

        // Independent stream: rd 4..7, all r1+r2
        in_valid = 1'b1;
        in_instr = mk(1, 2, 4);
        for (int c = 1; c <= 8; c++) begin
            tick();
            in_valid = (c < 4);
            in_instr = mk(1, 2, 4 + c);
            check("stream_wb_en", 32'(wb_en), 32'((c >= 3) && (c <= 6)));
            if (c >= 3 && c <= 6) begin
                check("stream_wb_addr", 32'(wb_addr), 32'(c + 1));
                check("stream_wb_data", wb_data, 32'd5);
            end
        end

        // RAW: A r5 = r1+r9 = 3, B r10 = r5+r1 = 5 (7 if stale r5 were read)
        in_valid = 1'b1;
        in_instr = mk(1, 9, 5);
        tick();
        in_instr = mk(5, 1, 10);
        tick();
        in_valid = 1'b0;
        check("raw_a_issue", alu_instr, mk(1, 9, 5));
        tick();
        check("raw_bubble", alu_instr, 32'd0);
        check("raw_a_wb_en", 32'(wb_en), 32'd1);
        check("raw_a_wb_data", wb_data, 32'd3);
        tick();
        check("raw_b_issue", alu_instr, mk(5, 1, 10));
        check("raw_gap", 32'(wb_en), 32'd0);
        tick();
        check("raw_b_wb_en", 32'(wb_en), 32'd1);
        check("raw_b_wb_addr", 32'(wb_addr), 32'd10);
        check("raw_b_wb_data", wb_data, 32'd5);
        tick();

        // Full FIFO: dependent chain r(12+k) = 2*r(11+k); r11 = 176
        k        = 0;
        n_wb     = 0;
        in_valid = 1'b1;
        in_instr = mk(11, 11, 12);
        acc      = in_ready;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (acc) k++;
            if (c == 7) check("full_in_ready_low", 32'(in_ready), 32'd0);
            if (c == 8) check("full_in_ready_back", 32'(in_ready), 32'd1);
            if (wb_en) begin
                check("full_wb_addr", 32'(wb_addr), 32'(12 + n_wb));
                check("full_wb_data", wb_data, 32'd176 << (n_wb + 1));
                n_wb++;
            end
            in_valid = (c <= 7);
            in_instr = mk(11 + k, 11 + k, 12 + k);
            acc      = in_valid && in_ready;
        end
        check("full_wb_count", 32'(n_wb), 32'd7);
        in_valid = 1'b0;

        // Flags: r20 = 0xFFFFFFFF + 1 -> 0, zero=1, carry=1
        in_valid = 1'b1;
        in_instr = mk(8, 9, 20);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("flags_wb_en", 32'(wb_en), 32'd1);
        check("flags_wb_data", wb_data, 32'd0);
        check("flags_zero_carry", {30'd0, out_zero, out_carry}, 32'd3);
        tick();
        check("flags_hold_valid", 32'(out_valid), 32'd0);
        check("flags_hold_zc", {30'd0, out_zero, out_carry}, 32'd3);
        check("flags_hold_data", wb_data, 32'd0);
        check("flags_hold_addr", 32'(wb_addr), 32'd20);

        // Reset mid-operation
        in_valid = 1'b1;
        in_instr = mk(1, 2, 21);
        tick();
        in_instr = mk(1, 2, 22);
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst_pre_wb_en", 32'(wb_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wb_en", 32'(wb_en), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_alu_instr", alu_instr, 32'd0);
        tick();
        rst_n = 1'b1;
        n_wb = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (wb_en || (alu_instr != 32'd0)) n_wb++;
        end
        check("midrst_no_activity", 32'(n_wb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
